// File: rtl/inv_trace_capture.sv
// Registered inverter with an event trace: every change of a_in (plus one start
// entry after reset) is timestamped and queued in a FIFO for a valid/ready reader.
module inv_trace_capture #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_in,
    output logic                     y_out,
    input  logic                     clear,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic                     rec_a,
    output logic                     rec_y,
    output logic [TS_W-1:0]          rec_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      state;
    logic            a_q;
    logic [TS_W-1:0] ts;

    // Each slot holds {a, ts}; y is always ~a so it is rebuilt on the way out.
    logic [TS_W:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;

    logic            event_p0;
    logic            full;
    logic            push;
    logic            pop;
    logic            ovf_set;
    logic [TS_W:0]   head;

    // Capture stage: decide what happens to the FIFO on this edge.
    always_comb begin
        event_p0 = (state == ST_INIT) || (a_in != a_q);
        full     = (cnt == FULL_CNT);
        pop      = rec_valid && rec_ready && !clear;
        push     = event_p0 && !clear && (!full || pop);
        ovf_set  = event_p0 && !clear && full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            a_q      <= 1'b0;
            y_out    <= 1'b1;
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= ST_RUN;
            a_q   <= a_in;
            y_out <= ~a_in;
            if (clear) begin
                ts       <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
                overflow <= 1'b0;
            end else begin
                ts <= ts + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
                if (ovf_set) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= {a_in, ts};
    end

    // Output stage: head read straight from storage, forced to zero when empty.
    always_comb begin
        head      = mem[rd_ptr];
        rec_valid = (cnt != '0);
        rec_a     = rec_valid & head[TS_W];
        rec_y     = rec_valid & ~head[TS_W];
        rec_ts    = rec_valid ? head[TS_W-1:0] : '0;
        count     = cnt;
    end

endmodule

// File: tb/tb_inv_trace_capture.sv
// Scoreboard bench for inv_trace_capture: a queue-based trace model predicts entries,
// a negedge monitor compares whatever the DUT presents against it.
module tb_inv_trace_capture;

    localparam int TS_W  = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_in;
    logic            y_out;
    logic            clear;
    logic            rec_valid;
    logic            rec_ready;
    logic            rec_a;
    logic            rec_y;
    logic [TS_W-1:0] rec_ts;
    logic [AW:0]     count;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit a;
        int ts;
    } entry_t;

    entry_t exp_q[$];
    int     m_cnt;
    int     m_ts;
    bit     m_aq;
    bit     m_y;
    bit     m_started;
    bit     m_ovf;
    bit     a_cur;

    inv_trace_capture #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .y_out     (y_out),
        .clear     (clear),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_a     (rec_a),
        .rec_y     (rec_y),
        .rec_ts    (rec_ts),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the trace is a list of {a, ts} entries bounded at DEPTH.
    initial begin : model
        bit ev;
        bit pop;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
                m_cnt = 0; m_ts = 0; m_aq = 0; m_y = 1; m_started = 0; m_ovf = 0;
            end else begin
                ev = !m_started || (a_in !== m_aq);
                if (clear) begin
                    exp_q.delete();
                    m_cnt = 0; m_ovf = 0; m_ts = 0;
                end else begin
                    pop = (m_cnt != 0) && rec_ready;
                    if (pop) m_cnt--;
                    if (ev) begin
                        if (m_cnt < DEPTH) begin
                            exp_q.push_back('{a: a_in, ts: m_ts});
                            m_cnt++;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                    m_ts = (m_ts + 1) % (1 << TS_W);
                end
                m_started = 1;
                m_aq      = a_in;
                m_y       = !a_in;
            end
        end
    end

    // Monitor: compare presented state and head entry; retire the head when accepted.
    initial begin : monitor
        entry_t h;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rec_valid", rec_valid, (m_cnt != 0));
                chk("count", count, m_cnt);
                chk("overflow", overflow, m_ovf);
                chk("y_out", y_out, m_y);
                if (exp_q.size() != 0) begin
                    h = exp_q[0];
                    chk("head_a", rec_a, h.a);
                    chk("head_y", rec_y, !h.a);
                    chk("head_ts", rec_ts, h.ts);
                    if (rec_ready && !clear) void'(exp_q.pop_front());
                end else if (rec_valid) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_entry: got rec_valid=1 expected rec_valid=0 at %0t", $time);
                end
            end
        end
    end

    task automatic step(input bit a, input bit rdy, input bit clr);
        a_in = a; rec_ready = rdy; clear = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic random_run(input int n, input int ready_pct);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) a_cur = !a_cur;
            step(a_cur, ($urandom_range(0, 99) < ready_pct), ($urandom_range(0, 80) == 0));
        end
    endtask

    initial begin
        rst = 1'b1; a_in = 1'b0; rec_ready = 1'b0; clear = 1'b0; a_cur = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", rec_valid, 0);
        chk("rst_y_out", y_out, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rec_ts", rec_ts, 0);
        chk("rst_rec_y", rec_y, 0);
        rst = 1'b0;

        // T1: start entry
        step(0, 0, 0);
        step(0, 0, 0);
        chk("t1_count", count, 1);
        chk("t1_valid", rec_valid, 1);
        chk("t1_ts", rec_ts, 0);
        chk("t1_rec_y", rec_y, 1);

        // T2: pop, then toggle captured at ts=10
        step(0, 1, 0);
        for (int i = 0; i < 20 && m_ts != 10; i++) step(0, 0, 0);
        a_cur = 1'b1;
        step(a_cur, 1, 0);
        chk("t2_valid", rec_valid, 1);
        chk("t2_ts", rec_ts, 10);
        chk("t2_a", rec_a, 1);
        chk("t2_y_out", y_out, 0);
        step(a_cur, 1, 0);

        // T3: overflow with reader stalled
        for (int i = 0; i < 10; i++) begin a_cur = !a_cur; step(a_cur, 0, 0); end
        chk("t3_count", count, 8);
        chk("t3_overflow", overflow, 1);
        repeat (10) step(a_cur, 1, 0);
        chk("t3_drained", count, 0);

        // T4: full with simultaneous push and pop
        step(a_cur, 0, 1);
        for (int i = 0; i < 8; i++) begin a_cur = !a_cur; step(a_cur, 0, 0); end
        a_cur = !a_cur;
        step(a_cur, 1, 0);
        chk("t4_count", count, 8);
        chk("t4_overflow", overflow, 0);
        repeat (9) step(a_cur, 1, 0);

        // T5: clear with entries held and an event in the same cycle
        for (int i = 0; i < 5; i++) begin a_cur = !a_cur; step(a_cur, 0, 0); end
        chk("t5_count_pre", count, 5);
        a_cur = !a_cur;
        step(a_cur, 0, 1);
        chk("t5_count", count, 0);
        chk("t5_overflow", overflow, 0);
        chk("t5_valid", rec_valid, 0);
        a_cur = !a_cur;
        step(a_cur, 0, 0);
        chk("t5_ts_restart", rec_ts, 0);
        repeat (2) step(a_cur, 1, 0);

        random_run(300, 70);
        random_run(150, 20);
        random_run(150, 95);

        // T6: asynchronous reset while draining
        for (int i = 0; i < 6; i++) begin a_cur = !a_cur; step(a_cur, 0, 0); end
        step(a_cur, 1, 0);
        step(a_cur, 1, 0);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", rec_valid, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_y_out", y_out, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (17) step(a_cur, 1, 0);
        a_cur = !a_cur;
        step(a_cur, 0, 0);
        chk("t6_wrap_ts", rec_ts, 1);
        repeat (2) step(a_cur, 1, 0);

        random_run(300, 60);
        repeat (12) step(a_cur, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
